alu_regfile_ctrl: RTL and testbench

//  Operand-fetch / writeback stage wrapped around the combinational ALU16. It holds a
//  16x16 register file and accepts one request per op: {sel, ra, rb, rd}.
//  It drives registered A/B/sel into ALU16, captures out + {N,L,Z,C,F} one cycle later,
//  and writes the result back to rd. A host write port loads registers for setup.

---
 rtl/alu_pkg.sv | 16 +
 rtl/alu_regfile_ctrl_regfile16.sv | 31 +++
 rtl/alu_regfile_ctrl.sv | 91 +++++++++
 tb/tb_alu_regfile_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, flag bit positions and FSM states shared by the ALU16 wrapper.
package alu_pkg;
    localparam logic [3:0] XOR  = 4'b0000;
    localparam logic [3:0] XNOR = 4'b0010;
    localparam logic [3:0] ADD  = 4'b0100;
    localparam logic [3:0] SUB  = 4'b0101;
    localparam logic [3:0] NOTA = 4'b0111;
    localparam logic [3:0] AND  = 4'b1000;
    localparam logic [3:0] OR   = 4'b1010;
    localparam int FLAG_N = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_F = 0;
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
endpackage

// File: rtl/alu_regfile_ctrl_regfile16.sv
// regfile16: 2**ADDR_W x DATA_W register file, one sync write port, async reads, R0 tied to zero.
module regfile16 #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
    assign rdata_dbg = (raddr_dbg == '0) ? '0 : mem[raddr_dbg];
endmodule

// File: rtl/alu_regfile_ctrl.sv
// alu_regfile_ctrl: operand fetch / writeback stage around ALU16 with a 16x16 register file.
module alu_regfile_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        flags_q,
    output logic [DATA_W-1:0] result_q,
    output logic              done,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] rf_a, rf_b;
    logic              accept, host_wr, wb, byp_a, byp_b;

    assign accept    = (state == IDLE) && req_valid;
    assign host_wr   = (state == IDLE) && host_we;
    assign wb        = (state == EXEC);
    assign req_ready = (state == IDLE);
    assign done      = (state == WB);
    // Host writes to R0 are dropped, so they must not bypass into operands either.
    assign byp_a     = host_wr && host_addr == req_ra && host_addr != '0;
    assign byp_b     = host_wr && host_addr == req_rb && host_addr != '0;

    regfile16 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .we        (host_wr || wb),
        .waddr     (wb ? rd_q : host_addr),
        .wdata     (wb ? alu_out : host_wdata),
        .raddr_a   (req_ra),
        .rdata_a   (rf_a),
        .raddr_b   (req_rb),
        .rdata_b   (rf_b),
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        state_nx = (state == IDLE) ? (req_valid ? EXEC : IDLE) :
                   (state == EXEC) ? WB : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A        <= '0;
            B        <= '0;
            sel      <= '0;
            rd_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            if (accept) begin
                A    <= byp_a ? host_wdata : rf_a;
                B    <= byp_b ? host_wdata : rf_b;
                sel  <= req_sel;
                rd_q <= req_rd;
            end
            if (wb) begin
                result_q <= alu_out;
                flags_q  <= alu_flags;
            end
        end
    end
endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// tb_alu_regfile_ctrl: drives the wrapper with an ALU16 behavioural stand-in and checks against a register-array model.
module tb_alu_regfile_ctrl;
    import alu_pkg::*;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready;
    logic [3:0]  req_sel = 0, req_ra = 0, req_rb = 0, req_rd = 0;
    logic        host_we = 0;
    logic [3:0]  host_addr = 0;
    logic [15:0] host_wdata = 0;
    logic [15:0] A, B, alu_out, result_q, dbg_data;
    logic [3:0]  sel, dbg_addr = 0;
    logic [4:0]  alu_flags, flags_q;
    logic        done;
    logic [15:0] ref_rf [16];
    int          passed = 0, total = 0;
    logic [3:0]  ops [7] = '{XOR, XNOR, ADD, SUB, NOTA, AND, OR};

    always #5 clk = ~clk;

    alu_regfile_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .A(A), .B(B), .sel(sel), .alu_out(alu_out), .alu_flags(alu_flags),
        .flags_q(flags_q), .result_q(result_q), .done(done),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ALU16 stand-in: returns {N,L,Z,C,F,out}
    function automatic logic [20:0] alu16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c, f;
        s = {1'b0, a} + {1'b0, b};
        r = '0;
        c = 1'b0;
        f = 1'b0;
        case (op)
            XOR:  r = a ^ b;
            XNOR: r = ~(a ^ b);
            ADD:  begin r = s[15:0]; c = s[16]; f = (a[15] == b[15]) && (r[15] != a[15]); end
            SUB:  begin s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16]; f = (a[15] != b[15]) && (r[15] != a[15]); end
            NOTA: r = ~a;
            AND:  r = a & b;
            OR:   r = a | b;
            default: r = '0;
        endcase
        return {$signed(a) < $signed(b), a < b, r == 16'd0, c, f, r};
    endfunction

    always_comb {alu_flags, alu_out} = alu16(sel, A, B);

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic host_wr(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        host_we = 1; host_addr = addr; host_wdata = data;
        @(negedge clk);
        host_we = 0;
        if (addr != 0) ref_rf[addr] = data;
        dbg_addr = addr;
        #1;
        total++;
        if (dbg_data !== ref_rf[addr]) $display("FAIL host_wr r%0d got %h want %h", addr, dbg_data, ref_rf[addr]);
        else passed++;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rd);
        logic [20:0] e;
        logic [15:0] ea, eb;
        ea = ref_rf[ra];
        eb = ref_rf[rb];
        e = alu16(op, ea, eb);
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) $display("FAIL op_ready_idle got %b want 1", req_ready);
        else passed++;
        req_valid = 1; req_sel = op; req_ra = ra; req_rb = rb; req_rd = rd;
        @(negedge clk);
        req_valid = 0;
        total++;
        if ({A, B, sel} !== {ea, eb, op}) $display("FAIL op_operands got A=%h B=%h sel=%h want A=%h B=%h sel=%h", A, B, sel, ea, eb, op);
        else passed++;
        total++;
        if ({done, req_ready} !== 2'b00) $display("FAIL op_exec_status got done=%b ready=%b want 0 0", done, req_ready);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, req_ready} !== 2'b10) $display("FAIL op_wb_status got done=%b ready=%b want 1 0", done, req_ready);
        else passed++;
        total++;
        if ({flags_q, result_q} !== e) $display("FAIL op_result got flags=%b res=%h want flags=%b res=%h", flags_q, result_q, e[20:16], e[15:0]);
        else passed++;
        if (rd != 0) ref_rf[rd] = e[15:0];
        @(negedge clk);
        dbg_addr = rd;
        #1;
        total++;
        if ({done, req_ready} !== 2'b01) $display("FAIL op_after_status got done=%b ready=%b want 0 1", done, req_ready);
        else passed++;
        total++;
        if (dbg_data !== ref_rf[rd]) $display("FAIL op_writeback r%0d got %h want %h", rd, dbg_data, ref_rf[rd]);
        else passed++;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        total++;
        if ({A, B, sel, flags_q, result_q, done, req_ready} !== {16'd0, 16'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b1})
            $display("FAIL reset_outputs got A=%h B=%h sel=%h flags=%b res=%h done=%b ready=%b want zeros ready=1", A, B, sel, flags_q, result_q, done, req_ready);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            ref_rf[i] = 16'd0;
            dbg_addr = i[3:0];
            #1;
            total++;
            if (dbg_data !== 16'd0) $display("FAIL reset_rf r%0d got %h want 0", i, dbg_data);
            else passed++;
        end
        rst = 0;
    endtask

    task automatic test_add;
        host_wr(1, 16'd69);
        host_wr(2, 16'd55);
        run_op(ADD, 1, 2, 3);
        total++;
        if (dbg_data !== 16'd124 || flags_q[FLAG_Z] !== 1'b0) $display("FAIL add_basic got r3=%h Z=%b want 007c Z=0", dbg_data, flags_q[FLAG_Z]);
        else passed++;
    endtask

    task automatic test_sub;
        host_wr(4, 16'd500);
        host_wr(5, 16'd500);
        host_wr(7, 16'd600);
        run_op(SUB, 4, 5, 6);
        total++;
        if (dbg_data !== 16'd0 || flags_q[FLAG_Z] !== 1'b1) $display("FAIL sub_zero got r6=%h Z=%b want 0000 Z=1", dbg_data, flags_q[FLAG_Z]);
        else passed++;
        run_op(SUB, 4, 7, 8);
        total++;
        if (dbg_data !== 16'hFF9C) $display("FAIL sub_neg got r8=%h want ff9c", dbg_data);
        else passed++;
    endtask

    task automatic test_logic;
        logic [15:0] want [4] = '{16'h1190, 16'h6E64, 16'h7FF4, 16'hC00B};
        logic [3:0]  lop  [4] = '{AND, XOR, OR, NOTA};
        host_wr(1, 16'h3FF4);
        host_wr(2, 16'h5190);
        for (int i = 0; i < 4; i++) begin
            run_op(lop[i], 1, 2, 9);
            total++;
            if (dbg_data !== want[i]) $display("FAIL logic_op%0d got r9=%h want %h", i, dbg_data, want[i]);
            else passed++;
        end
    endtask

    task automatic test_r0;
        run_op(ADD, 1, 2, 0);
        total++;
        if (dbg_data !== 16'd0 || result_q !== 16'h9184) $display("FAIL r0_dest got r0=%h res=%h want 0000 9184", dbg_data, result_q);
        else passed++;
        host_wr(0, 16'd1234);
        total++;
        if (dbg_data !== 16'd0) $display("FAIL r0_host got %h want 0", dbg_data);
        else passed++;
    endtask

    task automatic test_bypass;
        @(negedge clk);
        host_we = 1; host_addr = 1; host_wdata = 16'd10;
        req_valid = 1; req_sel = ADD; req_ra = 1; req_rb = 1; req_rd = 2;
        @(negedge clk);
        ref_rf[1] = 16'd10;
        req_valid = 0; host_addr = 5; host_wdata = 16'h7777;
        total++;
        if (A !== 16'd10 || B !== 16'd10) $display("FAIL bypass_operands got A=%h B=%h want 000a 000a", A, B);
        else passed++;
        @(negedge clk);
        host_we = 0;
        total++;
        if (done !== 1'b1 || result_q !== 16'd20) $display("FAIL bypass_result got done=%b res=%h want 1 0014", done, result_q);
        else passed++;
        ref_rf[2] = 16'd20;
        @(negedge clk);
        dbg_addr = 2;
        #1;
        total++;
        if (dbg_data !== 16'd20) $display("FAIL bypass_wb got r2=%h want 0014", dbg_data);
        else passed++;
        dbg_addr = 5;
        #1;
        total++;
        if (dbg_data !== ref_rf[5]) $display("FAIL host_we_busy got r5=%h want %h", dbg_data, ref_rf[5]);
        else passed++;
        dbg_addr = 1;
        #1;
        total++;
        if (dbg_data !== 16'd10) $display("FAIL bypass_hostwr got r1=%h want 000a", dbg_data);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] r3;
        r3 = ref_rf[3] + 2 * ref_rf[2];
        @(negedge clk);
        req_valid = 1; req_sel = ADD; req_ra = 3; req_rb = 2; req_rd = 3;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (req_ready !== (i % 3 == 0) || done !== (i % 3 == 2))
                $display("FAIL b2b_cycle%0d got ready=%b done=%b want %b %b", i, req_ready, done, i % 3 == 0, i % 3 == 2);
            else passed++;
            if (i == 5) req_valid = 0;
            if (i < 6) @(negedge clk);
        end
        ref_rf[3] = r3;
        dbg_addr = 3;
        #1;
        total++;
        if (dbg_data !== r3) $display("FAIL b2b_result got r3=%h want %h", dbg_data, r3);
        else passed++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) host_wr(4'($urandom_range(0, 15)), 16'($urandom));
            run_op(ops[$urandom_range(0, 6)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    task automatic test_rst_exec;
        host_wr(1, 16'd5);
        @(negedge clk);
        req_valid = 1; req_sel = ADD; req_ra = 1; req_rb = 1; req_rd = 3;
        @(negedge clk);
        req_valid = 0;
        rst = 1;
        #1;
        total++;
        if ({A, B, sel, flags_q, result_q, done, req_ready} !== {16'd0, 16'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b1})
            $display("FAIL rst_exec_outputs got A=%h B=%h sel=%h flags=%b res=%h done=%b ready=%b want zeros ready=1", A, B, sel, flags_q, result_q, done, req_ready);
        else passed++;
        for (int i = 0; i < 16; i++) ref_rf[i] = 16'd0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || req_ready !== 1'b1) $display("FAIL rst_exec_idle%0d got done=%b ready=%b want 0 1", i, done, req_ready);
            else passed++;
        end
        dbg_addr = 3;
        #1;
        total++;
        if (dbg_data !== 16'd0) $display("FAIL rst_exec_nowb got r3=%h want 0", dbg_data);
        else passed++;
        run_op(ADD, 1, 1, 3);
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_logic;
        test_r0;
        test_bypass;
        test_back_to_back;
        test_random;
        test_rst_exec;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
